// File: rtl/pckthandler_ml_if.sv
// Byte-stream bus between the lane aligner, the CSI-2 packet handler and the pixel unpacker.
// The master drives the aligned input beats; the slave (packet handler) drives payload and status.
interface pckthandler_ml_if #(
  parameter int unsigned NUM_LANES = 2
);
  localparam int unsigned BW = $clog2(NUM_LANES) + 1;

  logic [8*NUM_LANES-1:0] in_stream;
  logic                   in_stream_valid;
  logic [8*NUM_LANES-1:0] out_stream;
  logic                   out_valid;
  logic [BW-1:0]          out_bytes;
  logic [5:0]             out_dt;
  logic                   frame_active;
  logic                   frame_valid;
  logic                   ecc_error;
  logic                   pkt_error;

  modport master (
    output in_stream, in_stream_valid,
    input  out_stream, out_valid, out_bytes, out_dt,
    input  frame_active, frame_valid, ecc_error, pkt_error
  );

  modport slave (
    input  in_stream, in_stream_valid,
    output out_stream, out_valid, out_bytes, out_dt,
    output frame_active, frame_valid, ecc_error, pkt_error
  );
endinterface

// File: rtl/pckthandler_ml.sv
// Multi-lane CSI-2 packet handler: header/ECC check, VC filter, frame tracking,
// long-packet payload forwarding with per-beat byte count and CRC stripping.
module pckthandler_ml #(
  parameter int unsigned NUM_LANES    = 2,
  parameter bit          VC_FILTER_EN = 1'b1,
  parameter logic [1:0]  VC_SEL       = 2'd0
) (
  input  logic           rxbyteclkhs,
  input  logic           reset,
  pckthandler_ml_if.slave bus
);
  localparam int unsigned BW = $clog2(NUM_LANES) + 1;
  localparam int unsigned HB = 4 / NUM_LANES;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} state_t;
  state_t state, state_next;

  logic [1:0]    beat_cnt;
  logic [29:0]   hdr_q;
  logic [29:0]   hdr_full;
  logic [15:0]   rem;
  logic [7:0]    di;
  logic [15:0]   wc;
  logic          valid;
  logic          hdr_last, hdr_eval, collecting, ecc_bad, vc_ok, accept, is_long, hdr_go;
  logic          emit, abort, rem_last;
  logic [BW-1:0] emit_cnt;

  function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
    logic [5:0] e;
    e[0] = ^(d & 24'hF12CB7);
    e[1] = ^(d & 24'hF2555B);
    e[2] = ^(d & 24'h749A6D);
    e[3] = ^(d & 24'hB8E38E);
    e[4] = ^(d & 24'hDF03F0);
    e[5] = ^(d & 24'hEFFC00);
    return e;
  endfunction

  assign valid = bus.in_stream_valid;

  // Header bytes land at their final offset as they arrive; byte3[7:6] is never stored.
  always_comb begin
    hdr_full = hdr_q;
    for (int unsigned j = 0; j < 3; j++) begin
      if (j / NUM_LANES == 32'(beat_cnt)) hdr_full[j*8 +: 8] = bus.in_stream[(j % NUM_LANES)*8 +: 8];
    end
    if (3 / NUM_LANES == 32'(beat_cnt)) hdr_full[29:24] = bus.in_stream[(3 % NUM_LANES)*8 +: 6];
  end

  always_ff @(posedge rxbyteclkhs) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (valid) state_next = hdr_last ? (hdr_go ? PAYLOAD : DRAIN) : HDR;
      HDR: begin
        if (!valid)        state_next = IDLE;
        else if (hdr_last) state_next = hdr_go ? PAYLOAD : DRAIN;
      end
      PAYLOAD: begin
        if (!valid)        state_next = IDLE;
        else if (rem_last) state_next = DRAIN;
      end
      DRAIN:   if (!valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    di         = hdr_full[7:0];
    wc         = hdr_full[23:8];
    hdr_last   = (32'(beat_cnt) == HB - 1);
    hdr_eval   = valid && (state == IDLE || state == HDR) && hdr_last;
    collecting = valid && (state == IDLE || state == HDR) && !hdr_last;
    ecc_bad    = (csi2_ecc(hdr_full[23:0]) != hdr_full[29:24]);
    vc_ok      = !VC_FILTER_EN || (di[7:6] == VC_SEL);
    accept     = hdr_eval && !ecc_bad && vc_ok;
    is_long    = (di[5:4] != 2'b00);
    hdr_go     = accept && is_long && (wc != '0);
    emit       = (state == PAYLOAD) && valid;
    abort      = (state == PAYLOAD) && !valid;
    rem_last   = (rem <= 16'(NUM_LANES));
    emit_cnt   = rem_last ? rem[BW-1:0] : BW'(NUM_LANES);
  end

  always_ff @(posedge rxbyteclkhs) begin
    if (reset) begin
      beat_cnt         <= '0;
      hdr_q            <= '0;
      rem              <= '0;
      bus.out_stream   <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_bytes    <= '0;
      bus.out_dt       <= '0;
      bus.frame_active <= 1'b0;
      bus.frame_valid  <= 1'b0;
      bus.ecc_error    <= 1'b0;
      bus.pkt_error    <= 1'b0;
    end else begin
      if (collecting) begin
        hdr_q    <= hdr_full;
        beat_cnt <= beat_cnt + 2'd1;
      end else begin
        beat_cnt <= '0;
      end

      if (accept && is_long) begin
        rem        <= wc;
        bus.out_dt <= di[5:0];
      end else if (emit) begin
        rem <= rem - 16'(emit_cnt);
      end

      bus.out_valid   <= emit;
      bus.out_bytes   <= emit ? emit_cnt : '0;
      bus.out_stream  <= emit ? bus.in_stream : '0;
      bus.frame_valid <= emit && bus.frame_active;

      if (accept && di[5:0] == 6'h00)      bus.frame_active <= 1'b1;
      else if (accept && di[5:0] == 6'h01) bus.frame_active <= 1'b0;

      bus.ecc_error <= hdr_eval && ecc_bad;
      bus.pkt_error <= abort;
    end
  end
endmodule

// File: tb/tb_pckthandler_ml.sv
// Directed bench for pckthandler_ml at 1, 2 and 4 lanes: short/long packets, ECC,
// VC filtering, truncated bursts and mid-packet reset.
module tb_pckthandler_ml;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pckthandler_ml_if #(.NUM_LANES(1)) if1 ();
  pckthandler_ml_if #(.NUM_LANES(2)) if2 ();
  pckthandler_ml_if #(.NUM_LANES(4)) if4 ();

  pckthandler_ml #(.NUM_LANES(1), .VC_FILTER_EN(1'b0), .VC_SEL(2'd0)) u1 (.rxbyteclkhs(clk), .reset(rst), .bus(if1));
  pckthandler_ml #(.NUM_LANES(2), .VC_FILTER_EN(1'b1), .VC_SEL(2'd0)) u2 (.rxbyteclkhs(clk), .reset(rst), .bus(if2));
  pckthandler_ml #(.NUM_LANES(4), .VC_FILTER_EN(1'b0), .VC_SEL(2'd0)) u4 (.rxbyteclkhs(clk), .reset(rst), .bus(if4));

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  q[$];
  logic        rec_ov[32], rec_fv[32], rec_fa[32], rec_ee[32], rec_pe[32];
  logic [31:0] rec_os[32];
  logic [2:0]  rec_ob[32];
  logic [5:0]  rec_dt[32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // CSI-2 header ECC written out as the per-parity-bit data-bit lists.
  function automatic logic [5:0] ecc_of(input logic [23:0] d);
    logic [5:0] e;
    e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return e;
  endfunction

  task automatic put_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [5:0] flip);
    q.push_back(di);
    q.push_back(wc[7:0]);
    q.push_back(wc[15:8]);
    q.push_back({2'b00, ecc_of({wc, di}) ^ flip});
  endtask

  task automatic put_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) q.push_back(first + 8'(i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int lanes, input logic [31:0] beat, input logic v);
    case (lanes)
      1: begin if1.in_stream = beat[7:0];  if1.in_stream_valid = v; end
      2: begin if2.in_stream = beat[15:0]; if2.in_stream_valid = v; end
      default: begin if4.in_stream = beat; if4.in_stream_valid = v; end
    endcase
  endtask

  task automatic sample(input int lanes, input int i);
    case (lanes)
      1: begin
        rec_ov[i] = if1.out_valid; rec_fv[i] = if1.frame_valid; rec_fa[i] = if1.frame_active;
        rec_ee[i] = if1.ecc_error; rec_pe[i] = if1.pkt_error;  rec_os[i] = 32'(if1.out_stream);
        rec_ob[i] = 3'(if1.out_bytes); rec_dt[i] = if1.out_dt;
      end
      2: begin
        rec_ov[i] = if2.out_valid; rec_fv[i] = if2.frame_valid; rec_fa[i] = if2.frame_active;
        rec_ee[i] = if2.ecc_error; rec_pe[i] = if2.pkt_error;  rec_os[i] = 32'(if2.out_stream);
        rec_ob[i] = 3'(if2.out_bytes); rec_dt[i] = if2.out_dt;
      end
      default: begin
        rec_ov[i] = if4.out_valid; rec_fv[i] = if4.frame_valid; rec_fa[i] = if4.frame_active;
        rec_ee[i] = if4.ecc_error; rec_pe[i] = if4.pkt_error;  rec_os[i] = if4.out_stream;
        rec_ob[i] = if4.out_bytes; rec_dt[i] = if4.out_dt;
      end
    endcase
  endtask

  // Sends q as one burst of nbeats, then tail idle cycles; rec[i] holds outputs after beat i's edge.
  task automatic run(input int lanes, input int nbeats, input int tail);
    logic [31:0] beat;
    for (int i = 0; i < nbeats + tail; i++) begin
      beat = '0;
      for (int k = 0; k < lanes; k++)
        if (i*lanes + k < q.size()) beat[8*k +: 8] = q[i*lanes + k];
      drive(lanes, beat, i < nbeats);
      tick();
      sample(lanes, i);
    end
    drive(lanes, '0, 1'b0);
    q.delete();
  endtask

  function automatic int ov_count(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(rec_ov[i]);
    return c;
  endfunction

  initial begin
    rst = 1'b1;
    drive(1, '0, 1'b0);
    drive(2, '0, 1'b0);
    drive(4, '0, 1'b0);
    tick();
    tick();
    check("rst_u2_flags", 32'({if2.out_valid, if2.frame_active, if2.frame_valid, if2.ecc_error, if2.pkt_error}), 32'h0);
    check("rst_u2_data", 32'({if2.out_stream, if2.out_bytes, if2.out_dt}), 32'h0);
    check("rst_u4_flags", 32'({if4.out_valid, if4.frame_active, if4.out_bytes}), 32'h0);
    rst = 1'b0;
    tick();

    // FS on VC=1 is filtered out
    put_hdr(8'h40, 16'h0000, 6'h00);
    run(2, 2, 1);
    check("vcrej_fa", 32'(rec_fa[2]), 32'h0);
    check("vcrej_ecc", 32'(rec_ee[1]), 32'h0);

    // FS on VC=0, hand-coded header
    q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h00);
    run(2, 2, 1);
    check("fs_fa_early", 32'(rec_fa[0]), 32'h0);
    check("fs_fa", 32'(rec_fa[1]), 32'h1);

    // Long packet DT=0x2A WC=5 inside the frame
    put_hdr(8'h2A, 16'd5, 6'h00);
    put_bytes(8'h11, 5);
    q.push_back(8'hC1); q.push_back(8'hC2); q.push_back(8'h00);
    run(2, 6, 2);
    check("lp_ov_hdr", 32'(rec_ov[1]), 32'h0);
    check("lp_b0_data", rec_os[2], 32'h1211);
    check("lp_b0_bytes", 32'(rec_ob[2]), 32'd2);
    check("lp_b1_data", rec_os[3], 32'h1413);
    check("lp_b1_bytes", 32'(rec_ob[3]), 32'd2);
    check("lp_b2_data", rec_os[4] & 32'hFF, 32'h15);
    check("lp_b2_bytes", 32'(rec_ob[4]), 32'd1);
    check("lp_ov_count", 32'(ov_count(8)), 32'd3);
    check("lp_dt", 32'(rec_dt[2]), 32'h2A);
    check("lp_fv", 32'({rec_fv[1], rec_fv[2], rec_fv[3], rec_fv[4], rec_fv[5]}), 32'b01110);

    // Single flipped ECC bit on a long header
    put_hdr(8'h2A, 16'd2, 6'h04);
    put_bytes(8'hAA, 4);
    run(2, 4, 1);
    check("ecc_pulse", 32'({rec_ee[0], rec_ee[1], rec_ee[2]}), 32'b010);
    check("ecc_no_ov", 32'(ov_count(5)), 32'd0);
    check("ecc_fa_kept", 32'(rec_fa[3]), 32'h1);

    // WC=8 burst cut after two payload beats
    put_hdr(8'h2B, 16'd8, 6'h00);
    put_bytes(8'h01, 8);
    run(2, 4, 2);
    check("cut_ov_count", 32'(ov_count(6)), 32'd2);
    check("cut_b1_data", rec_os[3], 32'h0403);
    check("cut_pe", 32'({rec_pe[3], rec_pe[4], rec_pe[5]}), 32'b010);
    check("cut_fv", 32'(rec_fv[4]), 32'h0);

    // FE with hand-coded ECC 0x07, then a long packet outside the frame
    q.push_back(8'h01); q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h07);
    run(2, 2, 1);
    check("fe_fa", 32'(rec_fa[1]), 32'h0);
    check("fe_ecc", 32'(rec_ee[1]), 32'h0);
    put_hdr(8'h2A, 16'd2, 6'h00);
    put_bytes(8'h5A, 1); q.push_back(8'hA5); put_bytes(8'hC1, 2);
    run(2, 4, 1);
    check("nofr_ov", 32'(rec_ov[2]), 32'h1);
    check("nofr_data", rec_os[2], 32'hA55A);
    check("nofr_fv", 32'(rec_fv[2]), 32'h0);

    // Four lanes: FS on VC=2 (no filter), then WC=6
    put_hdr(8'h80, 16'h0000, 6'h00);
    run(4, 1, 1);
    check("l4_fa", 32'(rec_fa[0]), 32'h1);
    put_hdr(8'h2A, 16'd6, 6'h00);
    put_bytes(8'h61, 6); q.push_back(8'hC1); q.push_back(8'hC2);
    run(4, 3, 1);
    check("l4_b0_data", rec_os[1], 32'h64636261);
    check("l4_b0_bytes", 32'(rec_ob[1]), 32'd4);
    check("l4_b1_data", rec_os[2] & 32'hFFFF, 32'h6665);
    check("l4_b1_bytes", 32'(rec_ob[2]), 32'd2);
    check("l4_ov_count", 32'(ov_count(4)), 32'd2);
    check("l4_fv", 32'({rec_fv[1], rec_fv[2], rec_fv[3]}), 32'b110);

    // One lane: FS, then WC=6
    put_hdr(8'h00, 16'h0000, 6'h00);
    run(1, 4, 1);
    check("l1_fa", 32'({rec_fa[2], rec_fa[3]}), 32'b01);
    put_hdr(8'h2A, 16'd6, 6'h00);
    put_bytes(8'h71, 6); q.push_back(8'hC1); q.push_back(8'hC2);
    run(1, 12, 1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("l1_data%0d", k), rec_os[4+k] & 32'hFF, 32'h71 + 32'(k));
      check($sformatf("l1_bytes%0d", k), 32'(rec_ob[4+k]), 32'd1);
    end
    check("l1_ov_count", 32'(ov_count(13)), 32'd6);

    // One lane: reset asserted mid-payload
    put_hdr(8'h2A, 16'd6, 6'h00);
    put_bytes(8'h81, 6);
    run(1, 6, 0);
    check("mid_ov_before", 32'(rec_ov[5]), 32'h1);
    drive(1, 32'h83, 1'b1);
    rst = 1'b1;
    tick();
    check("mid_rst_flags", 32'({if1.out_valid, if1.frame_active, if1.frame_valid, if1.ecc_error, if1.pkt_error}), 32'h0);
    check("mid_rst_data", 32'({if1.out_stream, if1.out_bytes, if1.out_dt}), 32'h0);
    rst = 1'b0;
    drive(1, '0, 1'b0);
    tick();
    check("mid_no_pe", 32'({if1.pkt_error, if1.out_valid}), 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
